imu_quat_delta_pipe: RTL and testbench
======================================

# imu_quat_delta_pipe

Parametrised, handshaked successor of the gyro-to-quaternion-delta stage. Accepts one angular-rate sample (wx, wy, wz) plus an integration step dt per valid/ready transfer. Produces the incremental rotation quaternion (dq0..dq3) through a fixed 3-stage stallable pipeline, with saturation reporting and a saturating overflow counter. Sits between the IMU sample front end and the quaternion integrator.

## Interface
- W, 16: signed gyro sample width.
- DTW, 32: unsigned dt width.
- QW, 16: signed output width; ONE = 2^(QW-1)-1.
- SHIFT, 14: right-shift applied to w*dt to form the vector part.
- CNTW, 16: saturation counter width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts the sample this cycle.
- wx, wy, wz  in  W  signed angular rate.
- dt  in  DTW  unsigned timestep, zero-extended.
- out_valid  out  1  dq outputs valid.
- out_ready  in  1  downstream accepts the output.
- dq0  out  QW  scalar part.
- dq1, dq2, dq3  out  QW  signed vector part.
- sat  out  1  at least one of dq1..dq3 of the current output was clamped.
- sat_cnt  out  CNTW  count of transferred outputs with sat=1; sticks at all-ones.

## Operation
- Global enable: en = !out_valid || out_ready. All stages advance only when en=1.
- in_ready = en && !rst. A transfer occurs when in_valid && in_ready.
- Stage 1: p_k = w_k * {1'b0, dt}, signed, W+DTW+1 bits. Stage valid v1 <= transfer.
- Stage 2: s_k = p_k >>> SHIFT (arithmetic shift, floor). Clamp to [-2^(QW-1), 2^(QW-1)-1]. sat2 = OR of the three clamp events. v2 <= v1.
- Stage 3: register dq1..dq3, sat and dq0. out_valid <= v2.
- dq0 without the macro: dq0 = ONE.
- Output transfer occurs when out_valid && out_ready. If sat=1 on that transfer and sat_cnt is not all-ones, sat_cnt increments.
- Bubbles propagate as invalid stages. Samples are never dropped, duplicated or reordered.
- While out_valid && !out_ready, all outputs hold stable.

## Timing
- Latency: a sample accepted at edge N appears with out_valid=1 after edge N+2 and is visible in cycle N+3. Throughput is 1 sample/cycle with out_ready=1.
- Under stall, up to 3 samples are in flight (stages 1–3). in_ready drops in the cycle after out_valid rises with out_ready=0.
- Reset values: dq0..dq3=0, sat=0, sat_cnt=0, out_valid=0, all stage valids=0. in_ready=0 while rst=1 and 1 in the first cycle after reset.
- Reset mid-stream discards all in-flight samples. The first post-reset output appears 3 cycles after the next transfer.
- out_ready may toggle with out_valid low; this has no effect.
- Simultaneous output transfer and input transfer is legal: the pipeline shifts and nothing is lost.

## Configuration
- IMU_QDELTA_SCALAR_CORR_EN defined: stage 3 computes m = dq1²+dq2²+dq3² (2QW+2 bits, unsigned). It sets dq0 = ONE - (m >> QW), clamped at 0. This is the second-order small-angle correction 1-|v|²/2. Latency is unchanged.
- Not defined: dq0 = ONE on every valid output. No squaring logic is synthesised.

## Test plan
(All cases use default parameters.)
- Basic: wx=1000, wy=-1000, wz=0, dt=32768, out_ready=1 -> 3 cycles later dq1=2000, dq2=-2000, dq3=0, sat=0. dq0=32767, or 32645 with IMU_QDELTA_SCALAR_CORR_EN.
- Saturation: wx=32767, wy=-32768, wz=1, dt=65536 -> dq1=32767, dq2=-32768, dq3=4, sat=1, sat_cnt=1 after transfer. With the macro, dq0=0 (clamped).
- Floor rounding: wx=-1, dt=1 -> dq1=-1; wx=1, dt=1 -> dq1=0.
- Backpressure: out_ready=0, in_valid=1 with samples A,B,C,D -> exactly A,B,C accepted, in_ready=0, outputs hold A. Release out_ready -> A,B,C,D emerge in order, one per cycle.
- Streaming: 100 back-to-back random samples with random out_ready -> output sequence matches the reference model. sat_cnt equals the model's count and saturates at 65535 under forced overflow.
- Reset mid-stream: assert rst for 1 cycle with 3 samples in flight -> out_valid=0, all outputs and sat_cnt=0 next cycle, no stale sample emitted afterwards.

Source files
------------

// File: rtl/imu_quat_delta_pipe.sv
// Gyro rate * dt to incremental rotation quaternion, 3-stage stallable valid/ready pipeline.
// Optional second-order scalar correction: define IMU_QDELTA_SCALAR_CORR_EN.
module imu_quat_delta_pipe #(
  parameter int W     = 16,
  parameter int DTW   = 32,
  parameter int QW    = 16,
  parameter int SHIFT = 14,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  wx,
  input  logic signed [W-1:0]  wy,
  input  logic signed [W-1:0]  wz,
  input  logic [DTW-1:0]       dt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [QW-1:0] dq0,
  output logic signed [QW-1:0] dq1,
  output logic signed [QW-1:0] dq2,
  output logic signed [QW-1:0] dq3,
  output logic                 sat,
  output logic [CNTW-1:0]      sat_cnt
);

  localparam int PW = W + DTW + 1;
  localparam logic signed [QW-1:0] ONE  = {1'b0, {(QW-1){1'b1}}};
  localparam logic signed [PW-1:0] QMAX = {{(PW-QW+1){1'b0}}, {(QW-1){1'b1}}};
  localparam logic signed [PW-1:0] QMIN = {{(PW-QW+1){1'b1}}, {(QW-1){1'b0}}};

  logic                 w_en;
  logic signed [W-1:0]  w_w     [3];
  logic signed [PW-1:0] w_prod  [3];
  logic signed [PW-1:0] w_sh    [3];
  logic signed [QW-1:0] w_clamp [3];
  logic [2:0]           w_clip;
  logic signed [QW-1:0] w_dq0;

  logic                 r_v1;
  logic signed [PW-1:0] r_p   [3];
  logic                 r_v2;
  logic signed [QW-1:0] r_s   [3];
  logic                 r_sat2;
  logic                 r_out_valid;
  logic signed [QW-1:0] r_dq  [3];
  logic signed [QW-1:0] r_dq0;
  logic                 r_sat;
  logic [CNTW-1:0]      r_sat_cnt;

  // One enable for the whole pipe: bubbles are carried, never squeezed out.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en && !rst;

  always_comb begin
    w_w[0] = wx;
    w_w[1] = wy;
    w_w[2] = wz;
    for (int unsigned k = 0; k < 3; k++) begin
      w_prod[k] = PW'(w_w[k]) * $signed(PW'(dt));
    end
  end

  always_comb begin
    w_clip = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_sh[k] = r_p[k] >>> SHIFT;
      if (w_sh[k] > QMAX) begin
        w_clamp[k] = QW'(QMAX);
        w_clip[k]  = 1'b1;
      end else if (w_sh[k] < QMIN) begin
        w_clamp[k] = QW'(QMIN);
        w_clip[k]  = 1'b1;
      end else begin
        w_clamp[k] = w_sh[k][QW-1:0];
      end
    end
  end

`ifdef IMU_QDELTA_SCALAR_CORR_EN
  localparam int QW2 = 2 * QW;
  logic signed [QW2-1:0] w_sq [3];
  logic [QW2+1:0]        w_m;
  logic [QW2+1:0]        w_msh;

  // dq0 = ONE - |v|^2/2 in Q(QW-1): the square sum is Q(2QW-2), so >> QW halves and rescales.
  always_comb begin
    w_m = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_sq[k] = QW2'(r_s[k]) * QW2'(r_s[k]);
      w_m     = w_m + {2'b00, w_sq[k]};
    end
    w_msh = w_m >> QW;
    if (w_msh > (QW2+2)'(ONE)) begin
      w_dq0 = '0;
    end else begin
      w_dq0 = ONE - QW'(w_msh);
    end
  end
`else
  assign w_dq0 = ONE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_sat2      <= 1'b0;
      r_sat       <= 1'b0;
      r_dq0       <= '0;
      r_p         <= '{default: '0};
      r_s         <= '{default: '0};
      r_dq        <= '{default: '0};
    end else if (w_en) begin
      r_v1        <= in_valid;
      r_v2        <= r_v1;
      r_out_valid <= r_v2;
      r_sat2      <= |w_clip;
      r_sat       <= r_sat2;
      r_dq0       <= w_dq0;
      for (int unsigned k = 0; k < 3; k++) begin
        r_p[k]  <= w_prod[k];
        r_s[k]  <= w_clamp[k];
        r_dq[k] <= r_s[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (r_out_valid && out_ready && r_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + CNTW'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign dq0       = r_dq0;
  assign dq1       = r_dq[0];
  assign dq2       = r_dq[1];
  assign dq3       = r_dq[2];
  assign sat       = r_sat;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_imu_quat_delta_pipe.sv
// Directed-vector and scoreboard bench for imu_quat_delta_pipe; a second instance with a
// 4-bit counter exercises saturation of sat_cnt.
module tb_imu_quat_delta_pipe;

  typedef struct {
    int          wx, wy, wz;
    int unsigned dt;
    int          q0n, q0c, q1, q2, q3;
    bit          sat;
  } vec_t;

  typedef struct {
    int q0, q1, q2, q3;
    bit sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] wx = '0, wy = '0, wz = '0;
  logic [31:0]        dt = '0;

  logic               in_ready, out_valid, sat;
  logic signed [15:0] dq0, dq1, dq2, dq3;
  logic [15:0]        sat_cnt;
  logic               in_ready_s, out_valid_s, sat_s;
  logic signed [15:0] dq0_s, dq1_s, dq2_s, dq3_s;
  logic [3:0]         sat_cnt_s;

  int   checks = 0;
  int   failures = 0;
  exp_t cur_exp;
  exp_t sbq[$];
  int   exp_cnt = 0;
  int   exp_cnt_s = 0;
  bit   prev_stall = 0;
  logic signed [15:0] h0, h1, h2, h3;
  logic h_sat;
  bit   stream_done;
  vec_t tbl[4];

  imu_quat_delta_pipe #(.W(16), .DTW(32), .QW(16), .SHIFT(14), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .wx(wx), .wy(wy), .wz(wz), .dt(dt), .out_valid(out_valid), .out_ready(out_ready),
    .dq0(dq0), .dq1(dq1), .dq2(dq2), .dq3(dq3), .sat(sat), .sat_cnt(sat_cnt));

  imu_quat_delta_pipe #(.W(16), .DTW(32), .QW(16), .SHIFT(14), .CNTW(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .wx(wx), .wy(wy), .wz(wz), .dt(dt), .out_valid(out_valid_s), .out_ready(out_ready),
    .dq0(dq0_s), .dq1(dq1_s), .dq2(dq2_s), .dq3(dq3_s), .sat(sat_s), .sat_cnt(sat_cnt_s));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic signed [15:0] a, b, c, input logic [31:0] d);
    exp_t   e;
    longint w[3];
    longint s, m;
    int     q[3];
    w[0] = a; w[1] = b; w[2] = c;
    e.sat = 1'b0;
    m = 0;
    for (int k = 0; k < 3; k++) begin
      s = (w[k] * longint'(d)) >>> 14;
      if (s > 32767) begin s = 32767; e.sat = 1'b1; end
      else if (s < -32768) begin s = -32768; e.sat = 1'b1; end
      q[k] = int'(s);
      m = m + s * s;
    end
    e.q1 = q[0]; e.q2 = q[1]; e.q3 = q[2];
`ifdef IMU_QDELTA_SCALAR_CORR_EN
    m = m >>> 16;
    e.q0 = (m > 32767) ? 0 : int'(32767 - m);
`else
    e.q0 = 32767;
`endif
    return e;
  endfunction

  function automatic exp_t tbl_exp(input vec_t v);
    exp_t e;
`ifdef IMU_QDELTA_SCALAR_CORR_EN
    e.q0 = v.q0c;
`else
    e.q0 = v.q0n;
`endif
    e.q1 = v.q1; e.q2 = v.q2; e.q3 = v.q3; e.sat = v.sat;
    return e;
  endfunction

  // Scoreboard: output order/values, counter model, and hold-under-stall.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
      sbq.delete();
      exp_cnt = 0;
      exp_cnt_s = 0;
    end else begin
      chk("sat_cnt", sat_cnt, exp_cnt);
      chk("sat_cnt_small", sat_cnt_s, exp_cnt_s);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_dq0", dq0, h0);
        chk("hold_dq1", dq1, h1);
        chk("hold_dq2", dq2, h2);
        chk("hold_dq3", dq3, h3);
        chk("hold_sat", sat, h_sat);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("dq0", dq0, e.q0);
          chk("dq1", dq1, e.q1);
          chk("dq2", dq2, e.q2);
          chk("dq3", dq3, e.q3);
          chk("sat", sat, e.sat);
          if (e.sat) begin
            if (exp_cnt < 65535) exp_cnt++;
            if (exp_cnt_s < 15) exp_cnt_s++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      h0 = dq0; h1 = dq1; h2 = dq2; h3 = dq3; h_sat = sat;
      if (in_valid && in_ready) sbq.push_back(cur_exp);
    end
  end

  task automatic send(input logic signed [15:0] a, b, c, input logic [31:0] d, input exp_t e);
    bit acc;
    wx = a; wy = b; wz = c; dt = d; cur_exp = e; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (sbq.size() == 0) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic send_rand();
    logic signed [15:0] a, b, c;
    logic [31:0] d;
    a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
    d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 70000));
    send(a, b, c, d, model(a, b, c, d));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1000, -1000, 0, 32768, 32767, 32645, 2000, -2000, 0, 1'b0};
    tbl[1] = '{32767, -32768, 1, 65536, 32767, 0, 32767, -32768, 4, 1'b1};
    tbl[2] = '{-1, 0, 0, 1, 32767, 32767, -1, 0, 0, 1'b0};
    tbl[3] = '{1, 0, 0, 1, 32767, 32767, 0, 0, 0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dq0", dq0, 0);
    chk("rst_dq1", dq1, 0);
    chk("rst_dq2", dq2, 0);
    chk("rst_dq3", dq3, 0);
    chk("rst_sat", sat, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Latency: accepted at edge N, out_valid first seen after edge N+2.
    out_ready = 1'b1;
    wx = 16'(tbl[0].wx); wy = 16'(tbl[0].wy); wz = 16'(tbl[0].wz); dt = tbl[0].dt;
    cur_exp = tbl_exp(tbl[0]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("lat_valid_n0", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_valid_n1", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("lat_valid_n2", out_valid, 1);
    @(posedge clk); #1;
    drain();

    for (int i = 1; i < 4; i++) begin
      send(16'(tbl[i].wx), 16'(tbl[i].wy), 16'(tbl[i].wz), tbl[i].dt, tbl_exp(tbl[i]));
      drain();
    end
    @(negedge clk);
    chk("sat_cnt_after_table", sat_cnt, 1);
    @(posedge clk); #1;

    // Backpressure: A,B,C fill the pipe, D must wait.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++)
      send(16'(i * 100), 16'(-i), 16'(0), 32'd16384, model(16'(i * 100), 16'(-i), 16'(0), 32'd16384));
    wx = 16'd400; wy = -16'sd4; wz = '0; dt = 32'd16384;
    cur_exp = model(16'd400, -16'sd4, 16'(0), 32'd16384);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_a", dq1, 100);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stream_valid", out_valid, 1);
      if (i == 0) chk("bp_d_accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    drain();

    // Streaming with random backpressure.
    stream_done = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) send_rand();
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Saturating burst: small counter must stick at all-ones.
    for (int i = 0; i < 20; i++)
      send(16'sd32767, -16'sd32768, 16'sd1, 32'd65536, tbl_exp(tbl[1]));
    drain();
    @(negedge clk);
    chk("sat_cnt_small_sticky", sat_cnt_s, 15);
    @(posedge clk); #1;

    // Reset with three samples in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(16'sd32767, 16'(i), 16'(0), 32'd65536, model(16'sd32767, 16'(i), 16'(0), 32'd65536));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_dq0", dq0, 0);
    chk("mid_rst_dq1", dq1, 0);
    chk("mid_rst_dq2", dq2, 0);
    chk("mid_rst_dq3", dq3, 0);
    chk("mid_rst_sat", sat, 0);
    chk("mid_rst_sat_cnt", sat_cnt, 0);
    chk("mid_rst_sat_cnt_small", sat_cnt_s, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_output", out_valid, 0);
      @(posedge clk); #1;
    end
    send(16'(tbl[0].wx), 16'(tbl[0].wy), 16'(tbl[0].wz), tbl[0].dt, tbl_exp(tbl[0]));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
